// File: rtl/mac_pkg.sv
// Shared definitions for the MAC generator/verifier pair: default widths and
// the verifier state encoding.
package mac_pkg;

  localparam int MAC_N          = 256;
  localparam int MAC_MAX_CHUNKS = 16;

  typedef enum logic [1:0] {
    COLLECT,
    WAIT_TAG,
    RESULT
  } mac_vstate_t;

endpackage

// File: rtl/mac_accum.sv
// MAC fold register: acc = XOR over chunks of (key ^ chunk), with the key
// captured on the first chunk so later key changes cannot disturb a message.
module mac_accum
  import mac_pkg::*;
#(
  parameter int N = MAC_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         first,
  input  logic         clear,
  input  logic [N-1:0] key,
  input  logic [N-1:0] data,
  output logic [N-1:0] acc
);

  logic [N-1:0] key_q;

  // first chunk restarts the fold with the live key; later chunks use key_q
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      key_q <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      if (first) begin
        key_q <= key;
        acc   <= key ^ data;
      end else begin
        acc <= acc ^ key_q ^ data;
      end
    end
  end

endmodule

// File: rtl/mac_verifier.sv
// Receive-side MAC check: folds incoming chunks, compares against the received
// tag and holds the verdict until the consumer takes it.
module mac_verifier
  import mac_pkg::*;
#(
  parameter int N          = MAC_N,
  parameter int MAX_CHUNKS = MAC_MAX_CHUNKS,
  localparam int CW        = $clog2(MAX_CHUNKS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  key,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          in_last,
  input  logic          tag_valid,
  output logic          tag_ready,
  input  logic [N-1:0]  tag,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_match,
  output logic          res_len_err,
  output logic [CW-1:0] chunk_cnt
);

  mac_vstate_t state, next_state;

  logic [N-1:0] acc;
  logic         in_fire;
  logic         tag_fire;
  logic         res_fire;
  logic         last_slot;
  logic         overflow;

  assign in_fire   = in_valid && in_ready;
  assign tag_fire  = tag_valid && tag_ready;
  assign res_fire  = res_valid && res_ready;
  assign last_slot = (chunk_cnt == CW'(MAX_CHUNKS - 1));
  assign overflow  = in_fire && !in_last && last_slot;

  mac_accum #(.N(N)) u_accum (
    .clk   (clk),
    .reset (reset),
    .en    (in_fire),
    .first (chunk_cnt == '0),
    .clear (res_fire),
    .key   (key),
    .data  (in_data),
    .acc   (acc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= COLLECT;
    else       state <= next_state;
  end

  // handshake readiness is a pure function of state
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    tag_ready  = 1'b0;
    res_valid  = 1'b0;
    unique case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_last)        next_state = WAIT_TAG;
          else if (last_slot) next_state = RESULT;
        end
      end
      WAIT_TAG: begin
        tag_ready = 1'b1;
        if (tag_valid) next_state = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) next_state = COLLECT;
      end
      default: next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chunk_cnt   <= '0;
      res_match   <= 1'b0;
      res_len_err <= 1'b0;
    end else begin
      if (in_fire) chunk_cnt <= chunk_cnt + CW'(1);
      if (overflow) begin
        res_len_err <= 1'b1;
        res_match   <= 1'b0;
      end
      if (tag_fire) res_match <= (acc == tag);
      if (res_fire) begin
        chunk_cnt   <= '0;
        res_match   <= 1'b0;
        res_len_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_verifier.sv
// Directed bench for mac_verifier at N=8, MAX_CHUNKS=4 with hand-computed MACs.
module tb_mac_verifier;

  localparam int N   = 8;
  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  key;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          in_last;
  logic          tag_valid;
  logic          tag_ready;
  logic [N-1:0]  tag;
  logic          res_valid;
  logic          res_ready;
  logic          res_match;
  logic          res_len_err;
  logic [CW-1:0] chunk_cnt;

  int compared   = 0;
  int mismatched = 0;

  mac_verifier #(.N(N), .MAX_CHUNKS(MAX)) dut (
    .clk         (clk),
    .reset       (reset),
    .key         (key),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .tag_valid   (tag_valid),
    .tag_ready   (tag_ready),
    .tag         (tag),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_match   (res_match),
    .res_len_err (res_len_err),
    .chunk_cnt   (chunk_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_chunk(input logic [N-1:0] k, input logic [N-1:0] d, input logic last);
    check("in_ready_before_chunk", 32'(in_ready), 32'd1);
    key      = k;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_tag(input logic [N-1:0] t);
    int waited = 0;
    while (!tag_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("tag_ready_wait", 32'(tag_ready), 32'd1);
    tag       = t;
    tag_valid = 1'b1;
    tick();
    tag_valid = 1'b0;
  endtask

  task automatic expect_verdict(input string name, input logic match, input logic len_err);
    check({name, "_res_valid"}, 32'(res_valid), 32'd1);
    check({name, "_match"}, 32'(res_match), 32'(match));
    check({name, "_len_err"}, 32'(res_len_err), 32'(len_err));
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("after_accept_res_valid", 32'(res_valid), 32'd0);
    check("after_accept_in_ready", 32'(in_ready), 32'd1);
    check("after_accept_cnt", 32'(chunk_cnt), 32'd0);
  endtask

  initial begin
    reset     = 1'b1;
    key       = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    tag_valid = 1'b0;
    tag       = '0;
    res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_tag_ready", 32'(tag_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_match", 32'(res_match), 32'd0);
    check("rst_len_err", 32'(res_len_err), 32'd0);
    check("rst_cnt", 32'(chunk_cnt), 32'd0);

    // 1: (A5^0F)^(A5^F0) = FF
    send_chunk(8'hA5, 8'h0F, 1'b0);
    check("t1_cnt1", 32'(chunk_cnt), 32'd1);
    send_chunk(8'hA5, 8'hF0, 1'b1);
    check("t1_cnt2", 32'(chunk_cnt), 32'd2);
    check("t1_wait_in_ready", 32'(in_ready), 32'd0);
    check("t1_wait_res_valid", 32'(res_valid), 32'd0);
    send_tag(8'hFF);
    expect_verdict("t1", 1'b1, 1'b0);
    check("t1_result_tag_ready", 32'(tag_ready), 32'd0);
    accept_result();

    // 2: A5^3C = 99
    send_chunk(8'hA5, 8'h3C, 1'b1);
    send_tag(8'h98);
    expect_verdict("t2a", 1'b0, 1'b0);
    accept_result();
    send_chunk(8'hA5, 8'h3C, 1'b1);
    send_tag(8'h99);
    expect_verdict("t2b", 1'b1, 1'b0);
    accept_result();

    // 3: key latched on first chunk, so second chunk still folds with A5
    send_chunk(8'hA5, 8'h0F, 1'b0);
    send_chunk(8'h00, 8'hF0, 1'b1);
    send_tag(8'hFF);
    expect_verdict("t3", 1'b1, 1'b0);
    accept_result();

    // 4: four chunks without last overflow; a pending tag must never be taken
    tag       = 8'h5A;
    tag_valid = 1'b1;
    send_chunk(8'hA5, 8'h01, 1'b0);
    check("t4_tag_ready1", 32'(tag_ready), 32'd0);
    send_chunk(8'hA5, 8'h02, 1'b0);
    check("t4_tag_ready2", 32'(tag_ready), 32'd0);
    send_chunk(8'hA5, 8'h03, 1'b0);
    check("t4_tag_ready3", 32'(tag_ready), 32'd0);
    send_chunk(8'hA5, 8'h04, 1'b0);
    check("t4_tag_ready4", 32'(tag_ready), 32'd0);
    expect_verdict("t4", 1'b0, 1'b1);
    check("t4_cnt", 32'(chunk_cnt), 32'd4);
    tag_valid = 1'b0;
    accept_result();
    check("t4_len_err_cleared", 32'(res_len_err), 32'd0);

    // 5: verdict held under backpressure; stray in_valid ignored in RESULT
    send_chunk(8'hA5, 8'h0F, 1'b0);
    send_chunk(8'hA5, 8'hF0, 1'b1);
    send_tag(8'hFF);
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int i = 0; i < 5; i++) begin
      expect_verdict("t5_hold", 1'b1, 1'b0);
      check("t5_hold_in_ready", 32'(in_ready), 32'd0);
      check("t5_hold_cnt", 32'(chunk_cnt), 32'd2);
      tick();
    end
    in_valid = 1'b0;
    accept_result();

    // 6: async reset drops a partial message
    send_chunk(8'hA5, 8'h11, 1'b0);
    check("t6_partial_cnt", 32'(chunk_cnt), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_cnt", 32'(chunk_cnt), 32'd0);
    check("t6_async_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    check("t6_post_res_valid", 32'(res_valid), 32'd0);
    send_chunk(8'hA5, 8'h0F, 1'b0);
    send_chunk(8'hA5, 8'hF0, 1'b1);
    send_tag(8'hFF);
    expect_verdict("t6", 1'b1, 1'b0);
    check("t6_cnt", 32'(chunk_cnt), 32'd2);
    accept_result();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
